// File: rtl/fir_xifu_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_xifu_lsu_ctrl : in-order CV-X-IF load/store sequencer for FIR XIFU    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_xifu_lsu_ctrl #(
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_wdata_i,
  input  logic [IdWidth-1:0] req_id_i,
  input  logic [4:0]         req_rd_i,
  output logic               mem_valid_o,
  input  logic               mem_ready_i,
  output logic [31:0]        mem_addr_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_wdata_o,
  output logic [IdWidth-1:0] mem_id_o,
  output logic [3:0]         mem_be_o,
  output logic [2:0]         mem_size_o,
  output logic               mem_last_o,
  input  logic               mem_result_valid_i,
  input  logic [31:0]        mem_result_rdata_i,
  input  logic [IdWidth-1:0] mem_result_id_i,
  input  logic               mem_result_err_i,
  output logic               ld_valid_o,
  output logic [4:0]         ld_rd_o,
  output logic [31:0]        ld_data_o,
  output logic [IdWidth-1:0] ld_id_o,
  output logic               err_o,
  output logic [IdWidth-1:0] err_id_o,
  output logic               busy_o
);

  localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic               we;
  } entry_t;

  state_e             state_q, state_d;
  logic               clr_pend_q, clr_pend_d;
  logic               err_pend_q, err_pend_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [4:0]         rd_q, rd_d;
  entry_t             fifo_q [MaxOutstanding];
  entry_t             fifo_d [MaxOutstanding];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               ld_valid_q, ld_valid_d;
  logic [4:0]         ld_rd_q, ld_rd_d;
  logic [31:0]        ld_data_q, ld_data_d;
  logic [IdWidth-1:0] ld_id_q, ld_id_d;
  logic               err_q, err_d;
  logic [IdWidth-1:0] err_id_q, err_id_d;

  entry_t w_head;
  logic   w_empty, w_push, w_resp, w_spur, w_bad, w_err, w_accept, w_clr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign w_head   = fifo_q[rd_ptr_q];
  assign w_empty  = (count_q == '0);
  assign w_push   = (state_q == ISSUE) && mem_ready_i;
  // A response during the handshake cycle always refers to the current head.
  assign w_resp   = mem_result_valid_i && !w_empty;
  assign w_spur   = mem_result_valid_i && w_empty;
  assign w_bad    = w_resp && (mem_result_err_i || (mem_result_id_i != w_head.id));
  assign w_err    = w_bad || w_spur;
  assign w_accept = req_valid_i && req_ready_o;
  assign w_clr    = (clear_i && (state_q != ISSUE)) || (w_push && (clear_i || clr_pend_q));

  assign req_ready_o = (state_q == IDLE) && (count_q < MaxCnt) && !clear_i;

  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q;
    err_pend_d = err_pend_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    id_d       = id_q;
    rd_d       = rd_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    ld_valid_d = w_resp && !w_bad && !w_head.we;
    ld_rd_d    = ld_valid_d ? w_head.rd : '0;
    ld_data_d  = ld_valid_d ? mem_result_rdata_i : '0;
    ld_id_d    = ld_valid_d ? w_head.id : '0;
    err_d      = w_err;
    err_id_d   = w_spur ? mem_result_id_i : (w_bad ? w_head.id : '0);

    if (w_push) begin
      fifo_d[wr_ptr_q] = {id_q, rd_q, we_q};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (w_resp) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (w_push && !w_resp) begin
      count_d = count_q + CntW'(1);
    end else if (!w_push && w_resp) begin
      count_d = count_q - CntW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          we_d       = req_we_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          id_d       = req_id_i;
          rd_d       = req_rd_i;
          err_pend_d = w_err;
          state_d    = ISSUE;
        end else if (w_err) begin
          state_d = FLUSH;
        end
      end
      ISSUE: begin
        // The request cannot be retracted, so clear and error wait for the handshake.
        if (clear_i) clr_pend_d = 1'b1;
        if (w_err)   err_pend_d = 1'b1;
        if (mem_ready_i) begin
          state_d    = (err_pend_q || w_err) ? FLUSH : IDLE;
          err_pend_d = 1'b0;
        end
      end
      FLUSH: begin
        if (w_empty && !w_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (w_clr) begin
      state_d    = IDLE;
      clr_pend_d = 1'b0;
      err_pend_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ld_valid_d = 1'b0;
      ld_rd_d    = '0;
      ld_data_d  = '0;
      ld_id_d    = '0;
      err_d      = 1'b0;
      err_id_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      clr_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      id_q       <= '0;
      rd_q       <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
      ld_data_q  <= '0;
      ld_id_q    <= '0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      err_pend_q <= err_pend_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      id_q       <= id_d;
      rd_q       <= rd_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ld_valid_q <= ld_valid_d;
      ld_rd_q    <= ld_rd_d;
      ld_data_q  <= ld_data_d;
      ld_id_q    <= ld_id_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
    end
  end

  assign mem_valid_o = (state_q == ISSUE);
  assign mem_addr_o  = mem_valid_o ? addr_q : '0;
  assign mem_we_o    = mem_valid_o && we_q;
  assign mem_wdata_o = mem_valid_o ? wdata_q : '0;
  assign mem_id_o    = mem_valid_o ? id_q : '0;
  assign mem_be_o    = mem_valid_o ? 4'b1111 : 4'b0000;
  assign mem_size_o  = mem_valid_o ? 3'b010 : 3'b000;
  assign mem_last_o  = mem_valid_o;

  assign ld_valid_o = ld_valid_q;
  assign ld_rd_o    = ld_rd_q;
  assign ld_data_o  = ld_data_q;
  assign ld_id_o    = ld_id_q;
  assign err_o      = err_q;
  assign err_id_o   = err_id_q;
  assign busy_o     = (state_q != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_xifu_lsu_ctrl : scenario and random-traffic bench for the LSU ctrl |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_xifu_lsu_ctrl;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, req_valid_i, req_ready_o, req_we_i;
  logic [31:0]   req_addr_i, req_wdata_i;
  logic [IW-1:0] req_id_i;
  logic [4:0]    req_rd_i;
  logic          mem_valid_o, mem_ready_i, mem_we_o, mem_last_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic [IW-1:0] mem_id_o;
  logic [3:0]    mem_be_o;
  logic [2:0]    mem_size_o;
  logic          mem_result_valid_i, mem_result_err_i;
  logic [31:0]   mem_result_rdata_i;
  logic [IW-1:0] mem_result_id_i;
  logic          ld_valid_o, err_o, busy_o;
  logic [4:0]    ld_rd_o;
  logic [31:0]   ld_data_o;
  logic [IW-1:0] ld_id_o, err_id_o;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic          we;
    logic [4:0]    rd;
    logic [IW-1:0] id;
    logic [31:0]   addr;
    logic [31:0]   wdata;
  } req_t;

  fir_xifu_lsu_ctrl #(.IdWidth(IW), .MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_id_i(req_id_i), .req_rd_i(req_rd_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_id_o(mem_id_o),
    .mem_be_o(mem_be_o), .mem_size_o(mem_size_o), .mem_last_o(mem_last_o),
    .mem_result_valid_i(mem_result_valid_i), .mem_result_rdata_i(mem_result_rdata_i),
    .mem_result_id_i(mem_result_id_i), .mem_result_err_i(mem_result_err_i),
    .ld_valid_o(ld_valid_o), .ld_rd_o(ld_rd_o), .ld_data_o(ld_data_o), .ld_id_o(ld_id_o),
    .err_o(err_o), .err_id_o(err_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [IW-1:0] id, input logic [4:0] rd);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_id_i    = id;
    req_rd_i    = rd;
  endtask

  // Presents a request, waits (bounded) for acceptance, then completes the handshake after stall cycles.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [IW-1:0] id, input logic [4:0] rd, input int stall);
    int n;
    n = 0;
    drive_req(we, addr, wdata, id, rd);
    #1;
    while (req_ready_o !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (n == 20) begin
      total++;
      $display("FAIL issue_accept_timeout got req_ready=%b exp 1", req_ready_o);
    end
    cyc();
    req_valid_i = 1'b0;
    repeat (stall) cyc();
    mem_ready_i = 1'b1;
    cyc();
    mem_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [IW-1:0] id, input logic [31:0] rdata, input logic err);
    mem_result_valid_i = 1'b1;
    mem_result_id_i    = id;
    mem_result_rdata_i = rdata;
    mem_result_err_i   = err;
    cyc();
    mem_result_valid_i = 1'b0;
    mem_result_err_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    total++; if (req_ready_o !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready_o); else passed++;
    total++; if (mem_valid_o !== 1'b0) $display("FAIL reset_mem_valid got %b exp 0", mem_valid_o); else passed++;
    total++; if (mem_be_o !== 4'h0) $display("FAIL reset_mem_be got %h exp 0", mem_be_o); else passed++;
    total++; if (mem_size_o !== 3'h0 || mem_last_o !== 1'b0) $display("FAIL reset_size_last got %h/%b exp 0/0", mem_size_o, mem_last_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else passed++;
    total++; if (ld_valid_o !== 1'b0 || err_o !== 1'b0) $display("FAIL reset_pulses got ld=%b err=%b exp 0/0", ld_valid_o, err_o); else passed++;
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_single_load();
    drive_req(1'b0, 32'h1000, 32'h0, 4'd3, 5'd5);
    #1;
    total++; if (req_ready_o !== 1'b1) $display("FAIL single_ready got %b exp 1", req_ready_o); else passed++;
    cyc();
    req_valid_i = 1'b0;
    total++; if (req_ready_o !== 1'b0) $display("FAIL single_ready_in_issue got %b exp 0", req_ready_o); else passed++;
    total++; if (mem_be_o !== 4'hF || mem_size_o !== 3'b010 || mem_last_o !== 1'b1 || mem_we_o !== 1'b0)
      $display("FAIL single_req_ctrl got be=%h size=%h last=%b we=%b exp F/2/1/0", mem_be_o, mem_size_o, mem_last_o, mem_we_o); else passed++;
    for (int s = 0; s < 3; s++) begin
      total++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h1000 || mem_id_o !== 4'd3)
        $display("FAIL single_stall_stable got v=%b addr=%h id=%0d exp 1/1000/3", mem_valid_o, mem_addr_o, mem_id_o); else passed++;
      if (s < 2) cyc();
    end
    mem_ready_i = 1'b1;
    cyc();
    mem_ready_i = 1'b0;
    total++; if (mem_valid_o !== 1'b0 || busy_o !== 1'b1 || req_ready_o !== 1'b1)
      $display("FAIL single_after_hs got v=%b busy=%b ready=%b exp 0/1/1", mem_valid_o, busy_o, req_ready_o); else passed++;
    respond(4'd3, 32'hDEADBEEF, 1'b0);
    total++; if (ld_valid_o !== 1'b1 || ld_rd_o !== 5'd5 || ld_data_o !== 32'hDEADBEEF || ld_id_o !== 4'd3 || err_o !== 1'b0)
      $display("FAIL single_wb got v=%b rd=%0d data=%h id=%0d err=%b exp 1/5/deadbeef/3/0", ld_valid_o, ld_rd_o, ld_data_o, ld_id_o, err_o); else passed++;
    cyc();
    total++; if (ld_valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL single_pulse_end got v=%b busy=%b exp 0/0", ld_valid_o, busy_o); else passed++;
  endtask

  task automatic test_back_pressure();
    issue(1'b1, 32'h2000, $urandom, 4'd1, 5'd0, 0);
    issue(1'b1, 32'h2004, $urandom, 4'd2, 5'd0, 1);
    total++; if (req_ready_o !== 1'b0 || busy_o !== 1'b1 || ld_valid_o !== 1'b0)
      $display("FAIL bp_full got ready=%b busy=%b ld=%b exp 0/1/0", req_ready_o, busy_o, ld_valid_o); else passed++;
    drive_req(1'b1, 32'h2008, $urandom, 4'd3, 5'd0);
    for (int s = 0; s < 2; s++) begin
      #1;
      total++; if (req_ready_o !== 1'b0 || mem_valid_o !== 1'b0) $display("FAIL bp_hold got ready=%b v=%b exp 0/0", req_ready_o, mem_valid_o); else passed++;
      cyc();
    end
    mem_result_valid_i = 1'b1;
    mem_result_id_i    = 4'd1;
    #1;
    total++; if (req_ready_o !== 1'b0) $display("FAIL bp_ready_in_resp got %b exp 0", req_ready_o); else passed++;
    cyc();
    mem_result_valid_i = 1'b0;
    #1;
    total++; if (req_ready_o !== 1'b1 || ld_valid_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL bp_freed got ready=%b ld=%b err=%b exp 1/0/0", req_ready_o, ld_valid_o, err_o); else passed++;
    cyc();
    req_valid_i = 1'b0;
    total++; if (mem_valid_o !== 1'b1 || mem_id_o !== 4'd3 || mem_we_o !== 1'b1)
      $display("FAIL bp_third_issue got v=%b id=%0d we=%b exp 1/3/1", mem_valid_o, mem_id_o, mem_we_o); else passed++;
    mem_ready_i = 1'b1;
    cyc();
    mem_ready_i = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      respond(4'(k), $urandom, 1'b0);
      total++; if (ld_valid_o !== 1'b0 || err_o !== 1'b0) $display("FAIL bp_store_resp got ld=%b err=%b exp 0/0", ld_valid_o, err_o); else passed++;
    end
    cyc();
    total++; if (busy_o !== 1'b0) $display("FAIL bp_drained got busy=%b exp 0", busy_o); else passed++;
  endtask

  task automatic test_push_pop();
    logic [31:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    issue(1'b0, 32'h3000, 32'h0, 4'd1, 5'd7, 0);
    drive_req(1'b0, 32'h3004, 32'h0, 4'd2, 5'd8);
    cyc();
    req_valid_i        = 1'b0;
    mem_ready_i        = 1'b1;
    mem_result_valid_i = 1'b1;
    mem_result_id_i    = 4'd1;
    mem_result_rdata_i = d1;
    cyc();
    mem_ready_i        = 1'b0;
    mem_result_valid_i = 1'b0;
    total++; if (ld_valid_o !== 1'b1 || ld_id_o !== 4'd1 || ld_rd_o !== 5'd7 || ld_data_o !== d1)
      $display("FAIL pp_head_wb got v=%b id=%0d rd=%0d data=%h exp 1/1/7/%h", ld_valid_o, ld_id_o, ld_rd_o, ld_data_o, d1); else passed++;
    total++; if (busy_o !== 1'b1 || req_ready_o !== 1'b1) $display("FAIL pp_count_one got busy=%b ready=%b exp 1/1", busy_o, req_ready_o); else passed++;
    respond(4'd2, d2, 1'b0);
    total++; if (ld_valid_o !== 1'b1 || ld_id_o !== 4'd2 || ld_rd_o !== 5'd8 || ld_data_o !== d2 || err_o !== 1'b0)
      $display("FAIL pp_second_wb got v=%b id=%0d rd=%0d data=%h err=%b exp 1/2/8/%h/0", ld_valid_o, ld_id_o, ld_rd_o, ld_data_o, err_o, d2); else passed++;
    cyc();
    total++; if (busy_o !== 1'b0) $display("FAIL pp_drained got busy=%b exp 0", busy_o); else passed++;
  endtask

  task automatic test_bus_error();
    issue(1'b0, 32'h4000, 32'h0, 4'd4, 5'd9, 0);
    issue(1'b0, 32'h4004, 32'h0, 4'd5, 5'd10, 0);
    respond(4'd4, $urandom, 1'b1);
    total++; if (err_o !== 1'b1 || err_id_o !== 4'd4 || ld_valid_o !== 1'b0 || req_ready_o !== 1'b0)
      $display("FAIL buserr_pulse got err=%b id=%0d ld=%b ready=%b exp 1/4/0/0", err_o, err_id_o, ld_valid_o, req_ready_o); else passed++;
    cyc();
    total++; if (err_o !== 1'b0 || req_ready_o !== 1'b0) $display("FAIL buserr_flush got err=%b ready=%b exp 0/0", err_o, req_ready_o); else passed++;
    respond(4'd5, 32'h5555AAAA, 1'b0);
    total++; if (ld_valid_o !== 1'b1 || ld_id_o !== 4'd5 || req_ready_o !== 1'b0)
      $display("FAIL buserr_drain got ld=%b id=%0d ready=%b exp 1/5/0", ld_valid_o, ld_id_o, req_ready_o); else passed++;
    cyc();
    total++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL buserr_recover got ready=%b busy=%b exp 1/0", req_ready_o, busy_o); else passed++;
  endtask

  task automatic test_mismatch();
    logic [31:0] d;
    d = $urandom;
    issue(1'b0, 32'h6000, 32'h0, 4'd6, 5'd1, 0);
    respond(4'd7, $urandom, 1'b0);
    total++; if (err_o !== 1'b1 || err_id_o !== 4'd6 || ld_valid_o !== 1'b0)
      $display("FAIL mismatch_pulse got err=%b id=%0d ld=%b exp 1/6/0", err_o, err_id_o, ld_valid_o); else passed++;
    cyc();
    cyc();
    total++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1) $display("FAIL mismatch_recover got busy=%b ready=%b exp 0/1", busy_o, req_ready_o); else passed++;
    respond(4'd9, $urandom, 1'b0);
    total++; if (err_o !== 1'b1 || err_id_o !== 4'd9 || ld_valid_o !== 1'b0)
      $display("FAIL spurious_pulse got err=%b id=%0d ld=%b exp 1/9/0", err_o, err_id_o, ld_valid_o); else passed++;
    cyc();
    cyc();
    total++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1) $display("FAIL spurious_count got busy=%b ready=%b exp 0/1", busy_o, req_ready_o); else passed++;
    issue(1'b0, 32'h6004, 32'h0, 4'd2, 5'd3, 0);
    respond(4'd2, d, 1'b0);
    total++; if (ld_valid_o !== 1'b1 || ld_data_o !== d || err_o !== 1'b0)
      $display("FAIL spurious_after_load got v=%b data=%h err=%b exp 1/%h/0", ld_valid_o, ld_data_o, err_o, d); else passed++;
    cyc();
  endtask

  task automatic test_clear_stall();
    drive_req(1'b0, 32'h7000, 32'h0, 4'd10, 5'd4);
    cyc();
    req_valid_i = 1'b0;
    clear_i     = 1'b1;
    #1;
    total++; if (req_ready_o !== 1'b0 || mem_valid_o !== 1'b1) $display("FAIL clear_issue got ready=%b v=%b exp 0/1", req_ready_o, mem_valid_o); else passed++;
    cyc();
    clear_i = 1'b0;
    for (int s = 0; s < 2; s++) begin
      total++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h7000 || mem_id_o !== 4'd10)
        $display("FAIL clear_held got v=%b addr=%h id=%0d exp 1/7000/10", mem_valid_o, mem_addr_o, mem_id_o); else passed++;
      if (s == 0) cyc();
    end
    mem_ready_i = 1'b1;
    cyc();
    mem_ready_i = 1'b0;
    total++; if (mem_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1)
      $display("FAIL clear_done got v=%b busy=%b ready=%b exp 0/0/1", mem_valid_o, busy_o, req_ready_o); else passed++;
    respond(4'd10, $urandom, 1'b0);
    total++; if (err_o !== 1'b1 || err_id_o !== 4'd10 || ld_valid_o !== 1'b0)
      $display("FAIL clear_late_resp got err=%b id=%0d ld=%b exp 1/10/0", err_o, err_id_o, ld_valid_o); else passed++;
    cyc();
    cyc();
    drive_req(1'b1, 32'h8000, 32'h12345678, 4'd11, 5'd0);
    cyc();
    req_valid_i = 1'b0;
    total++; if (mem_valid_o !== 1'b1) $display("FAIL rst_mid_issue_pre got v=%b exp 1", mem_valid_o); else passed++;
    rst_i = 1'b1;
    cyc();
    total++; if (mem_valid_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0 || mem_id_o !== 4'h0)
      $display("FAIL rst_mid_issue_mem got v=%b addr=%h be=%h we=%b wdata=%h id=%0d exp all 0", mem_valid_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o, mem_id_o); else passed++;
    total++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || ld_valid_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL rst_mid_issue_ctl got ready=%b busy=%b ld=%b err=%b exp 1/0/0/0", req_ready_o, busy_o, ld_valid_o, err_o); else passed++;
    rst_i = 1'b0;
    cyc();
  endtask

  // Random in-order traffic; the model is just a queue of pushed requests.
  task automatic test_random();
    req_t        pend[$];
    req_t        r, h;
    logic        have;
    logic [31:0] d;
    int          stall;
    for (int it = 0; it < 40 || pend.size() > 0; it++) begin
      have = 1'b0;
      if (it < 40 && pend.size() < 2 && (pend.size() == 0 || $urandom_range(0, 1) == 1)) begin
        r.we = 1'($urandom); r.rd = 5'($urandom); r.id = 4'($urandom);
        r.addr = $urandom; r.wdata = $urandom;
        drive_req(r.we, r.addr, r.wdata, r.id, r.rd);
        #1;
        total++; if (req_ready_o !== 1'b1) $display("FAIL rnd_ready got %b exp 1 (outstanding %0d)", req_ready_o, pend.size()); else passed++;
        cyc();
        req_valid_i = 1'b0;
        total++; if (mem_valid_o !== 1'b1 || mem_addr_o !== r.addr || mem_we_o !== r.we || mem_id_o !== r.id || mem_wdata_o !== r.wdata)
          $display("FAIL rnd_mem_req got v=%b addr=%h we=%b id=%0d wdata=%h exp 1/%h/%b/%0d/%h",
                   mem_valid_o, mem_addr_o, mem_we_o, mem_id_o, mem_wdata_o, r.addr, r.we, r.id, r.wdata); else passed++;
        stall = $urandom_range(0, 2);
        repeat (stall) cyc();
        mem_ready_i = 1'b1;
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          h = pend.pop_front();
          d = $urandom;
          have = 1'b1;
          mem_result_valid_i = 1'b1;
          mem_result_id_i    = h.id;
          mem_result_rdata_i = d;
        end
        cyc();
        mem_ready_i        = 1'b0;
        mem_result_valid_i = 1'b0;
        pend.push_back(r);
      end else begin
        #1;
        if (pend.size() == 2) begin
          total++; if (req_ready_o !== 1'b0) $display("FAIL rnd_full_ready got %b exp 0", req_ready_o); else passed++;
        end
        h = pend.pop_front();
        d = $urandom;
        have = 1'b1;
        respond(h.id, d, 1'b0);
      end
      if (have) begin
        total++; if (ld_valid_o !== !h.we || err_o !== 1'b0)
          $display("FAIL rnd_resp_kind got ld=%b err=%b exp %b/0", ld_valid_o, err_o, !h.we); else passed++;
        if (!h.we) begin
          total++; if (ld_id_o !== h.id || ld_rd_o !== h.rd || ld_data_o !== d)
            $display("FAIL rnd_wb got id=%0d rd=%0d data=%h exp %0d/%0d/%h", ld_id_o, ld_rd_o, ld_data_o, h.id, h.rd, d); else passed++;
        end
      end
    end
    cyc();
    total++; if (busy_o !== 1'b0) $display("FAIL rnd_drained got busy=%b exp 0", busy_o); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; req_id_i = '0; req_rd_i = '0;
    mem_ready_i = 1'b0; mem_result_valid_i = 1'b0; mem_result_err_i = 1'b0;
    mem_result_rdata_i = '0; mem_result_id_i = '0;
    test_reset();
    test_single_load();
    test_back_pressure();
    test_push_pop();
    test_bus_error();
    test_mismatch();
    test_clear_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_xifu_lsu_ctrl.md
# fir_xifu_lsu_ctrl

Sequencer for FIR XIFU loads/stores (`XFIRLW`/`XFIRSW`) on the CV-X-IF memory interface. It sits between the EX stage and the core's memory port:
- holds each request stable until the core accepts it;
- tracks outstanding transactions in order;
- returns load data for XIFU register-file writeback;
- back-pressures EX through `req_ready_o`.

## Interface
Parameters:
- `IdWidth`, 4, width of the X-IF instruction id
- `MaxOutstanding`, 2, pending-transaction FIFO depth (power of 2, ≥1)

Ports:
- `clk_i` in 1: single clock
- `rst_i` in 1: reset, synchronous, active-high
- `clear_i` in 1: pipeline flush (sync)
- `req_valid_i` in 1: EX presents a memory op
- `req_ready_o` out 1: op accepted this cycle when high with `req_valid_i`
- `req_we_i` in 1: 1 = store
- `req_addr_i` in 32: word address
- `req_wdata_i` in 32: store data
- `req_id_i` in IdWidth: instruction id
- `req_rd_i` in 5: XIFU destination register (loads)
- `mem_valid_o` out 1: X-IF mem request valid
- `mem_ready_i` in 1: core accepts request
- `mem_addr_o` out 32, `mem_we_o` out 1, `mem_wdata_o` out 32, `mem_id_o` out IdWidth: request fields
- `mem_be_o` out 4: constant 4'b1111 while valid, else 0
- `mem_size_o` out 3: 3'b010 (word) while valid, else 0
- `mem_last_o` out 1: 1 while valid
- `mem_result_valid_i` in 1, `mem_result_rdata_i` in 32, `mem_result_id_i` in IdWidth, `mem_result_err_i` in 1: in-order responses
- `ld_valid_o` out 1: one-cycle load writeback pulse
- `ld_rd_o` out 5, `ld_data_o` out 32, `ld_id_o` out IdWidth: writeback fields
- `err_o` out 1: one-cycle pulse on bus error or id mismatch
- `err_id_o` out IdWidth: id of the faulting entry
- `busy_o` out 1: state ≠ IDLE or FIFO non-empty

## Operation
- FSM states:
  - IDLE: `req_ready_o = (count < MaxOutstanding)`. A request accepted while ready is latched into output registers → ISSUE.
  - ISSUE: `mem_valid_o = 1`. All request fields are held stable. On `mem_ready_i` the entry {id, rd, we} is pushed to the FIFO → IDLE. `req_ready_o = 0`.
  - FLUSH: entered from any state when an error is detected (after ISSUE completes its handshake, if in ISSUE). `req_ready_o = 0`. Returns to IDLE when `count == 0`.
- FIFO: in order, `MaxOutstanding` entries, with count and wrap-around read/write pointers.
  - Push on `mem_valid_o & mem_ready_i`.
  - Pop on `mem_result_valid_i`.
  - Simultaneous push and pop leaves `count` unchanged.
  - A response in the handshake cycle belongs to the older head entry.
- Response handling (registered, one cycle later):
  - head.we = 0 and no error → `ld_valid_o = 1`, `ld_rd_o` = head.rd, `ld_data_o` = rdata, `ld_id_o` = head.id.
  - Stores produce no writeback pulse.
  - `mem_result_err_i`, or `mem_result_id_i ≠ head.id` → `err_o = 1`, `err_id_o` = head.id, no `ld_valid_o`; the entry is popped and the FSM goes to FLUSH.
  - `mem_result_valid_i` with the FIFO empty is spurious: no pop, `err_o = 1`, `err_id_o = mem_result_id_i`.
- `clear_i` has priority over new requests:
  - IDLE/FLUSH: FIFO emptied, FSM → IDLE next cycle, pending response outputs suppressed.
  - ISSUE with `mem_ready_i = 0`: the request is not retracted; clear is deferred until the handshake completes, then FIFO emptied (including the just-pushed entry), FSM → IDLE.
  - Responses for cleared entries that arrive after a clear are treated as spurious.

## Timing
- Reset (`rst_i` sampled high at a clock edge): state IDLE, `count = 0`, pointers 0. All outputs 0 except `req_ready_o = 1` (IDLE, FIFO empty).
- Request latency: accept at cycle N → `mem_valid_o` high at N+1. Minimum issue interval is 2 cycles (IDLE/ISSUE alternation).
- Load latency: `mem_result_valid_i` at cycle M → `ld_valid_o` at M+1. `ld_valid_o` and `err_o` are mutually exclusive and last exactly one cycle.
- `req_ready_o` is combinational from state and count and does not depend on `req_valid_i`.
- Reset mid-transaction drops `mem_valid_o` immediately. System-level reset is shared with the core, so this does not violate X-IF rules.

## Test plan
- Single load: `req_valid_i` with addr 0x1000, id 3, rd 5, we 0 → `mem_valid_o` next cycle with addr 0x1000; `mem_ready_i` after 2 stall cycles (fields stable throughout); response rdata 0xDEADBEEF id 3 → `ld_valid_o` one cycle later with rd 5, data 0xDEADBEEF, id 3.
- Back-pressure: 3 stores ids 1,2,3 with responses withheld, `MaxOutstanding = 2` → `req_ready_o` low after 2 handshakes, `busy_o` = 1; response id 1 → third request accepted. No `ld_valid_o` at any point.
- Same-cycle push/pop: handshake on id 2 concurrent with response for id 1 → `count` stays 1, next response matches id 2.
- Bus error: load id 4 response with `mem_result_err_i = 1` → `err_o` pulse with `err_id_o = 4`, no `ld_valid_o`, `req_ready_o` low until FIFO drained.
- Id mismatch / spurious: response id 7 against head id 6 → `err_o` with `err_id_o = 6`; response with empty FIFO id 9 → `err_o` with `err_id_o = 9`, `count` stays 0.
- Clear during stalled ISSUE: `clear_i` with `mem_ready_i = 0` → `mem_valid_o` held until `mem_ready_i`, then FIFO empty, IDLE, `busy_o = 0` next cycle. Reset asserted mid-ISSUE → all outputs 0 except `req_ready_o = 1` after the clock edge.
